// File: rtl/pong_pkg.sv
// Shared constants, types and helpers for the VGA Pong design.
package pong_pkg;

  // Default 640x480@60 raster.
  localparam int unsigned VgaHVisible = 640;
  localparam int unsigned VgaHFp      = 16;
  localparam int unsigned VgaHSync    = 96;
  localparam int unsigned VgaHBp      = 48;
  localparam int unsigned VgaVVisible = 480;
  localparam int unsigned VgaVFp      = 10;
  localparam int unsigned VgaVSync    = 2;
  localparam int unsigned VgaVBp      = 33;

  localparam int unsigned BallSize  = 8;
  localparam int unsigned PadW      = 8;
  localparam int unsigned PadH      = 64;
  localparam int unsigned BallSpeed = 2;
  localparam int unsigned PadSpeed  = 2;

  localparam int unsigned CoordW = 10;
  localparam int unsigned RgbW   = 12;

  localparam logic [RgbW-1:0] ColBlank  = 12'h000;
  localparam logic [RgbW-1:0] ColBall   = 12'hFFF;
  localparam logic [RgbW-1:0] ColPaddle = 12'h0F0;

  typedef logic [CoordW-1:0]        coord_t;
  typedef logic signed [CoordW:0]   scoord_t;

  typedef enum logic [1:0] {PixBlank, PixBack, PixPaddle, PixBall} pix_kind_e;

  // True when p lies in [lo, lo+len); widened so lo+len cannot wrap.
  function automatic logic in_span(coord_t p, coord_t lo, int unsigned len);
    return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < ({1'b0, lo} + (CoordW + 1)'(len)));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters, raw syncs, active-video flag and per-frame start strobe.
module vga_timing
  import pong_pkg::*;
#(
  parameter int unsigned HVisible = VgaHVisible,
  parameter int unsigned HFp      = VgaHFp,
  parameter int unsigned HSync    = VgaHSync,
  parameter int unsigned HBp      = VgaHBp,
  parameter int unsigned VVisible = VgaVVisible,
  parameter int unsigned VFp      = VgaVFp,
  parameter int unsigned VSync    = VgaVSync,
  parameter int unsigned VBp      = VgaVBp
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pix_en_i,
  output logic [CoordW-1:0] h_count_o,
  output logic [CoordW-1:0] v_count_o,
  output logic              h_sync_o,
  output logic              v_sync_o,
  output logic              active_o,
  output logic              frame_start_o
);

  localparam coord_t HLast      = CoordW'(HVisible + HFp + HSync + HBp - 1);
  localparam coord_t VLast      = CoordW'(VVisible + VFp + VSync + VBp - 1);
  localparam coord_t HAct       = CoordW'(HVisible);
  localparam coord_t VAct       = CoordW'(VVisible);
  localparam coord_t HSyncStart = CoordW'(HVisible + HFp);
  localparam coord_t HSyncEnd   = CoordW'(HVisible + HFp + HSync);
  localparam coord_t VSyncStart = CoordW'(VVisible + VFp);
  localparam coord_t VSyncEnd   = CoordW'(VVisible + VFp + VSync);

  coord_t h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_i) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + CoordW'(1);
      end else begin
        h_d = h_q + CoordW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_count_o     = h_q;
  assign v_count_o     = v_q;
  assign h_sync_o      = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
  assign v_sync_o      = !((v_q >= VSyncStart) && (v_q < VSyncEnd));
  assign active_o      = (h_q < HAct) && (v_q < VAct);
  // Held for a whole pixel tick because the counters only move on pix_en.
  assign frame_start_o = (h_q == '0) && (v_q == VAct);

endmodule

// File: rtl/pong_vga_top.sv
// VGA Pong top: 25 MHz pixel enable, per-frame ball/paddle update and registered renderer.
module pong_vga_top
  import pong_pkg::*;
#(
  parameter int unsigned HVisible = VgaHVisible,
  parameter int unsigned HFp      = VgaHFp,
  parameter int unsigned HSync    = VgaHSync,
  parameter int unsigned HBp      = VgaHBp,
  parameter int unsigned VVisible = VgaVVisible,
  parameter int unsigned VFp      = VgaVFp,
  parameter int unsigned VSync    = VgaVSync,
  parameter int unsigned VBp      = VgaVBp,
  parameter int unsigned PaddleH  = PadH
) (
  input  logic            clk,
  input  logic            reset_in,
  output logic            h_sync,
  output logic            v_sync,
  output logic [RgbW-1:0] rgb
);

  localparam coord_t  BallX0 = CoordW'(HVisible / 2);
  localparam coord_t  BallY0 = CoordW'(VVisible / 2);
  localparam coord_t  PadY0  = CoordW'(VVisible / 2);
  localparam coord_t  PadX   = '0;
  localparam scoord_t Zero   = '0;
  localparam scoord_t XMax   = scoord_t'(HVisible - BallSize);
  localparam scoord_t XMin   = scoord_t'(PadW);
  localparam scoord_t YMax   = scoord_t'(VVisible - BallSize);
  localparam scoord_t PadMax = scoord_t'(VVisible - PaddleH);
  localparam scoord_t PadOfs = scoord_t'(PaddleH / 2 - BallSize / 2);
  localparam scoord_t BSpd   = scoord_t'(BallSpeed);
  localparam scoord_t PSpd   = scoord_t'(PadSpeed);

  logic   clk_25;
  logic   pix_en;
  coord_t h_count, v_count;
  logic   h_sync_raw, v_sync_raw, active, frame_start;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) clk_25 <= 1'b0;
    else           clk_25 <= ~clk_25;
  end

  assign pix_en = clk_25;

  vga_timing #(
    .HVisible(HVisible),
    .HFp     (HFp),
    .HSync   (HSync),
    .HBp     (HBp),
    .VVisible(VVisible),
    .VFp     (VFp),
    .VSync   (VSync),
    .VBp     (VBp)
  ) u_timing (
    .clk_i        (clk),
    .rst_ni       (reset_in),
    .pix_en_i     (pix_en),
    .h_count_o    (h_count),
    .v_count_o    (v_count),
    .h_sync_o     (h_sync_raw),
    .v_sync_o     (v_sync_raw),
    .active_o     (active),
    .frame_start_o(frame_start)
  );

  coord_t  ball_x_q, ball_x_d, ball_y_q, ball_y_d, paddle_y_q, paddle_y_d;
  scoord_t dx_q, dx_d, dy_q, dy_d;
  scoord_t next_x, next_y, pad_tgt, pad_diff;

  always_comb begin
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    paddle_y_d = paddle_y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    next_x     = $signed({1'b0, ball_x_q}) + dx_q;
    next_y     = $signed({1'b0, ball_y_q}) + dy_q;
    // Paddle chases the ball centre using the pre-update ball position.
    pad_tgt    = $signed({1'b0, ball_y_q}) - PadOfs;
    if (pad_tgt < Zero)        pad_tgt = Zero;
    else if (pad_tgt > PadMax) pad_tgt = PadMax;
    pad_diff   = pad_tgt - $signed({1'b0, paddle_y_q});

    if (pix_en && frame_start) begin
      if (next_x >= XMax) begin
        ball_x_d = coord_t'(XMax);
        dx_d     = -BSpd;
      end else if (dx_q[CoordW] && (next_x <= XMin)) begin
        ball_x_d = coord_t'(XMin);
        dx_d     = BSpd;
      end else begin
        ball_x_d = next_x[CoordW-1:0];
      end

      if (next_y >= YMax) begin
        ball_y_d = coord_t'(YMax);
        dy_d     = -BSpd;
      end else if (next_y <= Zero) begin
        ball_y_d = '0;
        dy_d     = BSpd;
      end else begin
        ball_y_d = next_y[CoordW-1:0];
      end

      if (pad_diff > PSpd)       paddle_y_d = paddle_y_q + coord_t'(PadSpeed);
      else if (pad_diff < -PSpd) paddle_y_d = paddle_y_q - coord_t'(PadSpeed);
      else                       paddle_y_d = pad_tgt[CoordW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      ball_x_q   <= BallX0;
      ball_y_q   <= BallY0;
      paddle_y_q <= PadY0;
      dx_q       <= BSpd;
      dy_q       <= BSpd;
    end else begin
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      paddle_y_q <= paddle_y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
    end
  end

  pix_kind_e       pix_kind;
  logic [RgbW-1:0] rgb_d, rgb_q;
  logic            h_sync_q, v_sync_q;

  always_comb begin
    pix_kind = PixBlank;
    if (active) begin
      pix_kind = PixBack;
      if (in_span(h_count, ball_x_q, BallSize) && in_span(v_count, ball_y_q, BallSize)) begin
        pix_kind = PixBall;
      end else if (in_span(h_count, PadX, PadW) && in_span(v_count, paddle_y_q, PaddleH)) begin
        pix_kind = PixPaddle;
      end
    end
    case (pix_kind)
      PixBall:   rgb_d = ColBall;
      PixPaddle: rgb_d = ColPaddle;
      default:   rgb_d = ColBlank;
    endcase
  end

  // Syncs go through the same register stage as rgb to stay pixel-aligned.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      rgb_q    <= ColBlank;
      h_sync_q <= 1'b1;
      v_sync_q <= 1'b1;
    end else if (pix_en) begin
      rgb_q    <= rgb_d;
      h_sync_q <= h_sync_raw;
      v_sync_q <= v_sync_raw;
    end
  end

  assign rgb    = rgb_q;
  assign h_sync = h_sync_q;
  assign v_sync = v_sync_q;

endmodule

// File: tb/tb_pong_vga_top.sv
// Bench for pong_vga_top on a scaled-down raster so several frames fit in a short run.
module tb_pong_vga_top;

  localparam int HV = 32, HFP = 2, HSW = 4, HBP = 2;
  localparam int VV = 24, VFP = 2, VSW = 2, VBP = 2;
  localparam int PH = 16, BS = 8, PW = 8, SPD = 2;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VT = VV + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic        h_sync, v_sync;
  logic [11:0] rgb;

  pong_vga_top #(
    .HVisible(HV), .HFp(HFP), .HSync(HSW), .HBp(HBP),
    .VVisible(VV), .VFp(VFP), .VSync(VSW), .VBp(VBP),
    .PaddleH (PH)
  ) dut (
    .clk     (clk),
    .reset_in(reset_in),
    .h_sync  (h_sync),
    .v_sync  (v_sync),
    .rgb     (rgb)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: raster position and game state in plain integers.
  int mh, mv, bx, by, ddx, ddy, py;
  int tick_no, hs_low, vs_low, fs_cnt, fs_last, fs_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0;
    bx = HV / 2; by = VV / 2; py = VV / 2;
    ddx = SPD; ddy = SPD;
    tick_no = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; fs_last = -1; fs_prev = -1;
  endtask

  function automatic logic [11:0] ref_rgb(int h, int v, int x, int y, int p);
    if (h >= HV || v >= VV) return 12'h000;
    if (h >= x && h < x + BS && v >= y && v < y + BS) return 12'hFFF;
    if (h < PW && v >= p && v < p + PH) return 12'h0F0;
    return 12'h000;
  endfunction

  task automatic model_frame();
    int nx, ny, tgt;
    tgt = by - PH / 2 + BS / 2;
    if (tgt < 0) tgt = 0;
    if (tgt > VV - PH) tgt = VV - PH;
    if (tgt - py > SPD) py = py + SPD;
    else if (tgt - py < -SPD) py = py - SPD;
    else py = tgt;
    nx = bx + ddx;
    ny = by + ddy;
    if (nx >= HV - BS) begin bx = HV - BS; ddx = -SPD; end
    else if (ddx < 0 && nx <= PW) begin bx = PW; ddx = SPD; end
    else bx = nx;
    if (ny >= VV - BS) begin by = VV - BS; ddy = -SPD; end
    else if (ny <= 0) begin by = 0; ddy = SPD; end
    else by = ny;
  endtask

  task automatic tick();
    logic [11:0] e_rgb;
    logic        e_hs, e_vs;
    logic        fs;
    e_rgb = ref_rgb(mh, mv, bx, by, py);
    e_hs  = !(mh >= HV + HFP && mh < HV + HFP + HSW);
    e_vs  = !(mv >= VV + VFP && mv < VV + VFP + VSW);
    fs    = (mh == 0 && mv == VV);
    if (fs) model_frame();
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
    @(posedge clk); #1;
    check("clk_25_high", dut.clk_25, 1);
    @(posedge clk); #1;
    tick_no++;
    check("clk_25_low", dut.clk_25, 0);
    check("rgb", rgb, e_rgb);
    check("h_sync", h_sync, e_hs);
    check("v_sync", v_sync, e_vs);
    check("h_count", dut.h_count, mh);
    check("v_count", dut.v_count, mv);
    check("frame_start", dut.frame_start, (mh == 0 && mv == VV));
    if (fs) begin
      check("ball_x", dut.ball_x_q, bx);
      check("ball_y", dut.ball_y_q, by);
      check("paddle_y", dut.paddle_y_q, py);
    end
    if (h_sync === 1'b0) hs_low++;
    if (v_sync === 1'b0) vs_low++;
    if (dut.frame_start === 1'b1) begin
      fs_cnt++;
      fs_prev = fs_last;
      fs_last = tick_no;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rgb"}, rgb, 12'h000);
    check({tag, "_h_sync"}, h_sync, 1);
    check({tag, "_v_sync"}, v_sync, 1);
    check({tag, "_ball_x"}, dut.ball_x_q, HV / 2);
    check({tag, "_ball_y"}, dut.ball_y_q, VV / 2);
    check({tag, "_paddle_y"}, dut.paddle_y_q, VV / 2);
    check({tag, "_h_count"}, dut.h_count, 0);
    check({tag, "_v_count"}, dut.v_count, 0);
    check({tag, "_frame_start"}, dut.frame_start, 0);
    check({tag, "_clk_25"}, dut.clk_25, 0);
  endtask

  initial begin
    model_reset();
    reset_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_reset_state("por");

    @(negedge clk);
    reset_in = 1'b1;
    run(10);
    check("early_ball_x", dut.ball_x_q, bx);
    check("early_ball_y", dut.ball_y_q, by);
    check("early_paddle_y", dut.paddle_y_q, py);

    // One full frame from (0,0): sync widths and a single frame_start.
    run(FRAME - 10);
    check("hsync_low_ticks", hs_low, HSW * VT);
    check("vsync_low_ticks", vs_low, VSW * HT);
    check("frame_start_ticks", fs_cnt, 1);

    run(5 * FRAME + int'($urandom_range(1, FRAME - 1)));
    check("frame_period", fs_last - fs_prev, FRAME);
    check("frames_seen", fs_cnt, 6);

    // Asynchronous reset mid-frame, well away from any clock edge.
    #($urandom_range(2, 8));
    reset_in = 1'b0;
    #1;
    check_reset_state("async");
    repeat ($urandom_range(1, 4)) @(posedge clk);
    @(negedge clk);
    model_reset();
    reset_in = 1'b1;

    // Long enough for the ball to hit all four limits.
    run(13 * FRAME + int'($urandom_range(0, HT)));
    check("frames_after_reset", fs_cnt, 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
